bpu_update_scheduler: RTL and testbench
=======================================

Name: bpu_update_scheduler

Overview:
- Sits between the execute-stage branch resolution logic and the branch history table (BHT) write port.
- Accepts resolved-branch updates from two sources: lane 0 is the main branch unit, lane 1 is the jump/secondary unit.
- Buffers updates in a small FIFO and issues at most one BHT update per cycle, only when the table port is free.
- Also runs a full-table clear sweep on request, one entry per cycle.

Parameters:
- IDX_W, 8, BHT index width; table holds 2^IDX_W entries.
- DEPTH, 4, update FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clear_req  in  1  single-cycle request to zero the whole BHT
- upd0_valid  in  1  lane 0 update present
- upd0_pc  in  IDX_W  lane 0 branch index
- upd0_taken  in  1  lane 0 resolved outcome
- upd0_ready  out  1  lane 0 accepted this cycle (combinational)
- upd1_valid, upd1_pc, upd1_taken, upd1_ready  same as lane 0, for lane 1
- port_busy  in  1  BHT port in use by another agent this cycle; no FIFO pop
- bht_we  out  1  registered write strobe to BHT
- bht_idx  out  IDX_W  registered write index
- bht_taken  out  1  registered outcome for counter update
- bht_clear  out  1  registered; force entry to 2'b00 (valid with bht_we)
- sweep_busy  out  1  high while clear sweep is in progress
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, while high):
  - All outputs 0, FIFO empty, state RUN.
  - Round-robin pointer favours lane 0.
  - Takes effect mid-sweep or mid-drain; nothing resumes after release.
- States:
  - RUN: accept and drain updates.
  - CLEAR: sweep the table.
- RUN, acceptance (room = DEPTH - fifo_count):
  - clear_req high: both readies 0.
  - room >= 2: readyX = 1 for each lane.
  - room == 1, one lane valid: that lane is ready.
  - room == 1, both lanes valid: only the round-robin-favoured lane is ready. The pointer then flips to the other lane.
  - room == 0: both readies 0.
  - Pointer changes only on that room==1 contention.
  - Accept = valid & ready. Both accepted in one cycle: lane 0 is written ahead of lane 1.
- RUN, issue:
  - Pop when fifo non-empty at the edge and port_busy == 0.
  - Next cycle: bht_we=1, bht_idx/bht_taken = head entry, bht_clear=0.
  - Otherwise bht_we=0; bht_idx/bht_taken hold their last values.
  - Enqueue and pop in the same cycle are legal. fifo_count = old + accepts - pop.
  - Latency: an update accepted at edge N into an empty FIFO with port free gives bht_we high in the cycle after edge N+1 (2 cycles).
  - Updates to the same index are issued in order, with no coalescing.
- RUN -> CLEAR (on clear_req at edge):
  - FIFO is flushed; pending updates are discarded.
  - Sweep counter = 0, sweep_busy = 1.
  - Any pop in that cycle is cancelled.
- CLEAR:
  - Each cycle: bht_we=1, bht_clear=1, bht_idx = counter, then counter++.
  - port_busy is ignored; clear has priority.
  - Both readies 0. clear_req is ignored.
  - After bht_idx = 2^IDX_W - 1 is issued: return to RUN, sweep_busy=0, bht_we=0 on the next cycle.
  - Sweep length is exactly 2^IDX_W cycles of bht_we.
- Counters wrap modulo their widths. FIFO pointers wrap at DEPTH. Overflow is impossible by construction.

Test Plan:
- Reset, then lane0 {pc=8'h10, taken=1} for one cycle, port free -> 2 cycles later bht_we=1, idx=8'h10, taken=1, clear=0 for exactly one cycle; fifo_count returns to 0.
- Both lanes valid for 3 consecutive cycles (lane0 pc 1,2,3; lane1 pc 81,82,83), port_busy=1 throughout:
  - cycles 1-2: both readies 1; fifo_count 2 then 4
  - cycle 3: both readies 0
  - release port_busy -> issue order 1,81,2,82, one per cycle.
- FIFO at 3, both lanes valid, pointer at lane 0 -> only upd0_ready=1 and count reaches 4; repeat at count 3 -> only upd1_ready=1.
- port_busy toggling 1,0,1,0 with 2 entries queued -> bht_we pulses only in cycles following port_busy=0; order preserved.
- 3 entries queued, then assert clear_req -> fifo_count=0 next cycle; 256 consecutive bht_we with clear=1, idx 0..255; sweep_busy high for 256 cycles; none of the queued updates issue; new updates accepted afterwards.
- Assert reset at sweep idx=100 -> all outputs 0 immediately; after release no sweep continues and state is RUN with empty FIFO.

Source files
------------

// File: rtl/bpu_update_scheduler_if.sv
// BHT update scheduler bus: two resolved-branch lanes in, BHT write port out.
// master = branch resolution side, slave = scheduler.
interface bpu_update_scheduler_if #(
  parameter int IDX_W = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clear_req;
  logic             upd0_valid;
  logic [IDX_W-1:0] upd0_pc;
  logic             upd0_taken;
  logic             upd0_ready;
  logic             upd1_valid;
  logic [IDX_W-1:0] upd1_pc;
  logic             upd1_taken;
  logic             upd1_ready;
  logic             port_busy;
  logic             bht_we;
  logic [IDX_W-1:0] bht_idx;
  logic             bht_taken;
  logic             bht_clear;
  logic             sweep_busy;
  logic [CW-1:0]    fifo_count;

  modport master (
    output clear_req, port_busy,
    output upd0_valid, upd0_pc, upd0_taken,
    output upd1_valid, upd1_pc, upd1_taken,
    input  upd0_ready, upd1_ready,
    input  bht_we, bht_idx, bht_taken, bht_clear,
    input  sweep_busy, fifo_count
  );

  modport slave (
    input  clear_req, port_busy,
    input  upd0_valid, upd0_pc, upd0_taken,
    input  upd1_valid, upd1_pc, upd1_taken,
    output upd0_ready, upd1_ready,
    output bht_we, bht_idx, bht_taken, bht_clear,
    output sweep_busy, fifo_count
  );
endinterface

// File: rtl/bpu_update_scheduler.sv
// Buffers two lanes of BHT updates, issues one per free port cycle, runs clear sweeps.
// Ports: clk, reset (async high), bus (slave side of bpu_update_scheduler_if).
module bpu_update_scheduler #(
  parameter int IDX_W = 8,
  parameter int DEPTH = 4
) (
  input logic                    clk,
  input logic                    reset,
  bpu_update_scheduler_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [IDX_W-1:0] LAST = '1;

  typedef enum logic {RUN, CLEAR} state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] q_idx [DEPTH];
  logic [DEPTH-1:0] q_tkn;
  logic [PW-1:0]    wr_ptr, wr_ptr1, rd_ptr;
  logic [CW-1:0]    count, room;
  logic             rr, rr_flip;
  logic             rdy0, rdy1;
  logic             acc0, acc1;
  logic             pop, go_clear;
  logic [IDX_W-1:0] sweep_cnt;

  logic             we_q, clr_q, tkn_q, busy_q;
  logic [IDX_W-1:0] idx_q;

  assign room = CW'(DEPTH) - count;

  // rr names the lane that wins a single free slot
  always_comb begin
    state_nx = state;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    rr_flip  = 1'b0;
    pop      = 1'b0;
    go_clear = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.clear_req) begin
          go_clear = 1'b1;
          state_nx = CLEAR;
        end else begin
          pop = (count != '0) && !bus.port_busy;
          if (room >= CW'(2)) begin
            rdy0 = 1'b1;
            rdy1 = 1'b1;
          end else if (room == CW'(1)) begin
            if (bus.upd0_valid && bus.upd1_valid) begin
              rdy0    = !rr;
              rdy1    = rr;
              rr_flip = 1'b1;
            end else begin
              rdy0 = bus.upd0_valid;
              rdy1 = bus.upd1_valid;
            end
          end
        end
      end
      CLEAR: begin
        if (sweep_cnt == LAST) state_nx = RUN;
      end
    endcase
  end

  assign acc0    = bus.upd0_valid && rdy0;
  assign acc1    = bus.upd1_valid && rdy1;
  // lane 1 lands behind lane 0 when both go in together
  assign wr_ptr1 = wr_ptr + PW'(acc0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr     <= 1'b0;
    end else if (go_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(acc0) + PW'(acc1);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(acc0) + CW'(acc1) - CW'(pop);
      if (rr_flip) rr <= !rr;
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) begin
      q_idx[wr_ptr] <= bus.upd0_pc;
      q_tkn[wr_ptr] <= bus.upd0_taken;
    end
    if (acc1) begin
      q_idx[wr_ptr1] <= bus.upd1_pc;
      q_tkn[wr_ptr1] <= bus.upd1_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      clr_q     <= 1'b0;
      tkn_q     <= 1'b0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      sweep_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          clr_q <= 1'b0;
          if (go_clear) begin
            we_q      <= 1'b0;
            busy_q    <= 1'b1;
            sweep_cnt <= '0;
          end else if (pop) begin
            we_q  <= 1'b1;
            idx_q <= q_idx[rd_ptr];
            tkn_q <= q_tkn[rd_ptr];
          end else begin
            we_q <= 1'b0;
          end
        end
        CLEAR: begin
          we_q      <= 1'b1;
          clr_q     <= 1'b1;
          idx_q     <= sweep_cnt;
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST) busy_q <= 1'b0;
        end
      endcase
    end
  end

  // readies are combinational, so force them low while reset is held
  assign bus.upd0_ready = rdy0 && !reset;
  assign bus.upd1_ready = rdy1 && !reset;
  assign bus.bht_we     = we_q;
  assign bus.bht_idx    = idx_q;
  assign bus.bht_taken  = tkn_q;
  assign bus.bht_clear  = clr_q;
  assign bus.sweep_busy = busy_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Bench for bpu_update_scheduler: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_bpu_update_scheduler;
  localparam int IDX_W = 8;
  localparam int DEPTH = 4;
  localparam int N     = 1 << IDX_W;

  logic clk = 1'b0;
  logic reset;

  bpu_update_scheduler_if #(.IDX_W(IDX_W), .DEPTH(DEPTH)) bus();

  bpu_update_scheduler #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] idx;
    logic       tk;
  } ent_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t q[$];
  bit   rr, sw;
  int   sctr;
  logic e_we, e_clr, e_busy, e_tk;
  logic [7:0] e_idx;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset;
    q.delete();
    rr = 0; sw = 0; sctr = 0;
    e_we = 0; e_clr = 0; e_busy = 0; e_tk = 0; e_idx = '0;
  endtask

  task automatic check_regs;
    check("we", 32'(bus.bht_we), 32'(e_we));
    check("clr", 32'(bus.bht_clear), 32'(e_clr));
    check("busy", 32'(bus.sweep_busy), 32'(e_busy));
    check("idx", 32'(bus.bht_idx), 32'(e_idx));
    check("count", 32'(bus.fifo_count), 32'(q.size()));
    if (e_we && !e_clr) check("taken", 32'(bus.bht_taken), 32'(e_tk));
  endtask

  task automatic check_zero;
    check("rst_rdy0", 32'(bus.upd0_ready), 0);
    check("rst_rdy1", 32'(bus.upd1_ready), 0);
    check("rst_we", 32'(bus.bht_we), 0);
    check("rst_idx", 32'(bus.bht_idx), 0);
    check("rst_taken", 32'(bus.bht_taken), 0);
    check("rst_clr", 32'(bus.bht_clear), 0);
    check("rst_busy", 32'(bus.sweep_busy), 0);
    check("rst_count", 32'(bus.fifo_count), 0);
  endtask

  // Entered and left at a falling edge.
  task automatic step(input bit cr, input bit v0, input logic [7:0] p0,
                      input bit t0, input bit v1, input logic [7:0] p1,
                      input bit t1, input bit pb);
    int   room;
    bit   r0, r1, a0, a1;
    ent_t e;
    bus.clear_req  = cr;
    bus.upd0_valid = v0; bus.upd0_pc = p0; bus.upd0_taken = t0;
    bus.upd1_valid = v1; bus.upd1_pc = p1; bus.upd1_taken = t1;
    bus.port_busy  = pb;
    #1;
    room = DEPTH - q.size();
    r0 = 0; r1 = 0;
    if (!sw && !cr) begin
      if (room >= 2) begin
        r0 = 1; r1 = 1;
      end else if (room == 1) begin
        if (v0 && v1) begin
          r0 = !rr; r1 = rr;
        end else begin
          r0 = v0; r1 = v1;
        end
      end
    end
    check("rdy0", 32'(bus.upd0_ready), 32'(r0));
    check("rdy1", 32'(bus.upd1_ready), 32'(r1));
    check_regs();
    @(posedge clk);
    a0 = v0 && r0;
    a1 = v1 && r1;
    if (sw) begin
      e_we = 1; e_clr = 1; e_idx = sctr[7:0];
      if (sctr == N - 1) begin
        sw = 0; e_busy = 0;
      end
      sctr++;
    end else if (cr) begin
      q.delete();
      sw = 1; sctr = 0; e_busy = 1; e_we = 0; e_clr = 0;
    end else begin
      e_clr = 0;
      if (q.size() > 0 && !pb) begin
        e = q.pop_front();
        e_we = 1; e_idx = e.idx; e_tk = e.tk;
      end else begin
        e_we = 0;
      end
      if (a0) q.push_back(ent_t'{idx: p0, tk: t0});
      if (a1) q.push_back(ent_t'{idx: p1, tk: t1});
      if (v0 && v1 && room == 1) rr = !rr;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit pb);
    for (int i = 0; i < n; i++) step(0, 0, 8'h0, 0, 0, 8'h0, 0, pb);
  endtask

  initial begin
    bit hit;
    reset = 1'b0;
    bus.clear_req = 0; bus.port_busy = 0;
    bus.upd0_valid = 0; bus.upd0_pc = '0; bus.upd0_taken = 0;
    bus.upd1_valid = 0; bus.upd1_pc = '0; bus.upd1_taken = 0;
    model_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_zero();
    reset = 1'b0;

    // single update, 2-cycle latency
    step(0, 1, 8'h10, 1, 0, 8'h0, 0, 0);
    idle(4, 0);

    // both lanes while port busy, then drain in order
    step(0, 1, 8'h01, 1, 1, 8'h81, 0, 1);
    step(0, 1, 8'h02, 0, 1, 8'h82, 1, 1);
    step(0, 1, 8'h03, 1, 1, 8'h83, 1, 1);
    idle(6, 0);

    // contention at count 3: lane 0 wins, then lane 1
    step(0, 1, 8'h21, 1, 1, 8'h31, 0, 1);
    step(0, 1, 8'h22, 0, 0, 8'h0, 0, 1);
    step(0, 1, 8'h23, 1, 1, 8'h33, 1, 1);
    idle(1, 0);
    step(0, 1, 8'h24, 0, 1, 8'h34, 1, 1);
    // port_busy toggling while draining
    idle(1, 1); idle(1, 0); idle(1, 1); idle(1, 0);
    idle(1, 1); idle(1, 0); idle(1, 1); idle(1, 0);
    idle(2, 0);

    // clear with 3 queued, full sweep, then new traffic
    step(0, 1, 8'h41, 1, 1, 8'h42, 1, 1);
    step(0, 1, 8'h43, 1, 0, 8'h0, 0, 1);
    step(1, 0, 8'h0, 0, 0, 8'h0, 0, 0);
    idle(N + 2, 0);
    step(0, 1, 8'h55, 1, 1, 8'h66, 0, 0);
    idle(4, 0);

    // reset in the middle of a sweep
    step(1, 0, 8'h0, 0, 0, 8'h0, 0, 1);
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      step(0, 0, 8'h0, 0, 0, 8'h0, 0, 0);
      hit = sw && e_we && (e_idx == 8'd100);
    end
    check("sweep_reach", 32'(hit), 1);
    reset = 1'b1;
    #1;
    check_zero();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero();
    reset = 1'b0;
    idle(3, 0);
    step(0, 1, 8'h77, 1, 0, 8'h0, 0, 0);
    idle(3, 0);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
           1'($urandom));
    end
    idle(N + 8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
